page_swap_writer: RTL
=====================

PAGE_SWAP_WRITER -- requirements
Module: page_swap_writer

Interface
REQ-001 SHALL have parameter PAGE_WORDS, default 64: words per page copied; legal range 2..4096.
REQ-002 SHALL have parameter ADDR_W, default 32: width of main-memory and HD word addresses.
REQ-003 SHALL have parameter DATA_W, default 32: instruction/data word width.
REQ-004 Clock  input  1  the single system clock; all state is updated on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 Start  input  1  one-cycle request to swap out one page; sampled only in IDLE.
REQ-007 Abort  input  1  cancels a transfer in progress.
REQ-008 PID  input  5  process being swapped; latched on Start.
REQ-009 MP_Base  input  ADDR_W  physical main-memory page base address (the MMU output); latched on Start.
REQ-010 HD_Base  input  ADDR_W  HD destination word index; latched on Start.
REQ-011 MP_Address  output  ADDR_W  main-memory read address.
REQ-012 MP_Data  input  DATA_W  main-memory read data, valid one cycle after its address.
REQ-013 HD_Address  output  ADDR_W  HD write address.
REQ-014 HD_WriteData  output  DATA_W  HD write data.
REQ-015 WriteHD  output  1  HD write strobe.
REQ-016 Busy  output  1  high in every state except IDLE.
REQ-017 Done  output  1  one-cycle pulse when a page has been fully written.
REQ-018 Aborted  output  1  one-cycle pulse when a transfer is cancelled.
REQ-019 PID_out  output  5  PID of the latched or last transfer.

Function
REQ-020 SHALL implement FSM IDLE, RD, WR, FIN, CHK (CHK exists only with the macro defined).
REQ-021 IDLE: Start=1 SHALL latch PID/MP_Base/HD_Base, clear word counter k, and go to RD.
REQ-022 RD: SHALL drive MP_Address=MP_Base+k and WriteHD=0, then go to WR.
REQ-023 WR: SHALL drive HD_Address=HD_Base+k, HD_WriteData=MP_Data and WriteHD=1; if k=PAGE_WORDS-1, SHALL go to FIN (or to CHK with the macro defined), else SHALL increment k and go to RD.
REQ-024 FIN: SHALL assert Done for one cycle and return to IDLE; per-page latency from the Start edge to Done high is 2*PAGE_WORDS+1 cycles (+1 with the macro defined).
REQ-025 Address arithmetic SHALL be modulo 2^ADDR_W; wrap-around is silent and SHALL NOT be flagged.
REQ-026 Start while Busy=1 SHALL be ignored; no queueing.
REQ-027 Abort=1 in any non-IDLE state SHALL force IDLE on the next edge, suppress WriteHD in that cycle, pulse Aborted, and SHALL NOT assert Done.
REQ-028 Abort and Start together in IDLE: Start SHALL win and Abort SHALL be ignored.
REQ-029 Abort arriving in the FIN cycle SHALL be ignored because Done is already committed.
REQ-030 WriteHD SHALL be high only in WR (or CHK); it SHALL be high for exactly PAGE_WORDS cycles per completed page.
REQ-031 HD_Address, HD_WriteData and MP_Address SHALL hold their last values outside the RD and WR states.

Reset
REQ-032 Reset low SHALL immediately force IDLE and set k=0, Busy=0, Done=0, Aborted=0, WriteHD=0, all addresses and data to 0, and PID_out=0.
REQ-033 Reset mid-transfer SHALL discard the transfer with no Done or Aborted pulse; words already written to the HD remain.

Configuration
REQ-034 Macro SWAP_CHECKSUM_EN, when defined: SHALL accumulate the sum (mod 2^DATA_W) of all words written; CHK SHALL write that sum to HD_Base+PAGE_WORDS with WriteHD=1, then go to FIN.
REQ-035 SWAP_CHECKSUM_EN, when undefined: no accumulator and no CHK state; WR goes directly to FIN.

Structure
REQ-036 The FSM state enum, PID width (5) and the default PAGE_WORDS SHALL live in the shared package yousei_pkg.
REQ-037 SHALL be a single module; the optional checksum accumulator SHALL be inline with no sub-module.

Verification
REQ-038 PAGE_WORDS=4, MP_Base=0x10, HD_Base=0x200, memory[0x10..0x13]=A,B,C,D, Start -> HD writes 0x200..0x203=A..D, Done high at cycle 9.
REQ-039 Start pulsed again at cycle 3 of a transfer -> ignored; exactly 4 WriteHD pulses; one Done.
REQ-040 Abort at cycle 4 -> at most 2 HD writes, Aborted pulse, no Done, Busy=0 on the next cycle.
REQ-041 MP_Base=0xFFFFFFFE, PAGE_WORDS=4 -> reads 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
REQ-042 Reset low at cycle 5 -> all outputs 0 immediately; no Done; a new Start after release completes normally.
REQ-043 SWAP_CHECKSUM_EN defined, data 1,2,3,4 -> fifth write 0x0000000A at HD_Base+4; Done at cycle 10.

Source files
------------

// File: rtl/yousei_pkg.sv
// yousei_pkg: shared state encoding and sizes for page_swap_writer.
// The CHK state is present only when SWAP_CHECKSUM_EN is defined.
package yousei_pkg;
  localparam int PID_W = 5;
  localparam int DEF_PAGE_WORDS = 64;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_FIN  = 3'd3
`ifdef SWAP_CHECKSUM_EN
    , S_CHK = 3'd4
`endif
  } state_e;
endpackage

// File: rtl/page_swap_writer_if.sv
// page_swap_writer_if: request, main-memory read and HD write signals of page_swap_writer.
interface page_swap_writer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                         Start;
  logic                         Abort;
  logic [yousei_pkg::PID_W-1:0] PID;
  logic [ADDR_W-1:0]            MP_Base;
  logic [ADDR_W-1:0]            HD_Base;
  logic [ADDR_W-1:0]            MP_Address;
  logic [DATA_W-1:0]            MP_Data;
  logic [ADDR_W-1:0]            HD_Address;
  logic [DATA_W-1:0]            HD_WriteData;
  logic                         WriteHD;
  logic                         Busy;
  logic                         Done;
  logic                         Aborted;
  logic [yousei_pkg::PID_W-1:0] PID_out;
  modport master (
    output Start, Abort, PID, MP_Base, HD_Base, MP_Data,
    input  MP_Address, HD_Address, HD_WriteData, WriteHD, Busy, Done, Aborted, PID_out
  );
  modport slave (
    input  Start, Abort, PID, MP_Base, HD_Base, MP_Data,
    output MP_Address, HD_Address, HD_WriteData, WriteHD, Busy, Done, Aborted, PID_out
  );
endinterface

// File: rtl/page_swap_writer.sv
// page_swap_writer: copies one PAGE_WORDS page from main memory to the HD, one word per RD/WR pair.
// Defining SWAP_CHECKSUM_EN appends a CHK cycle writing the word sum to HD_Base+PAGE_WORDS.
module page_swap_writer
  import yousei_pkg::*;
#(
  parameter int PAGE_WORDS = DEF_PAGE_WORDS,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input logic clk,
  input logic rst_n,
  page_swap_writer_if.slave bus
);
  localparam int K_W = $clog2(PAGE_WORDS);
  state_e            state, nxt;
  logic [K_W-1:0]    k;
  logic [PID_W-1:0]  pid;
  logic [ADDR_W-1:0] mp_base, hd_base, mp_hold, hd_addr_hold, rd_addr, wr_addr;
  logic [DATA_W-1:0] hd_data_hold, wr_data;
  logic              aborted, active, last, writing;
`ifdef SWAP_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  assign writing = state == S_WR || state == S_CHK;
  assign wr_addr = (state == S_CHK) ? hd_base + ADDR_W'(PAGE_WORDS) : hd_base + ADDR_W'(k);
  assign wr_data = (state == S_CHK) ? sum : bus.MP_Data;
`else
  assign writing = state == S_WR;
  assign wr_addr = hd_base + ADDR_W'(k);
  assign wr_data = bus.MP_Data;
`endif
  assign last    = k == K_W'(PAGE_WORDS - 1);
  assign active  = state != S_IDLE && state != S_FIN;
  assign rd_addr = mp_base + ADDR_W'(k);
  // Address/data outputs show the live value in their state and hold it elsewhere
  assign bus.MP_Address   = (state == S_RD) ? rd_addr : mp_hold;
  assign bus.HD_Address   = writing ? wr_addr : hd_addr_hold;
  assign bus.HD_WriteData = writing ? wr_data : hd_data_hold;
  assign bus.WriteHD      = writing && !bus.Abort;
  assign bus.Busy         = state != S_IDLE;
  assign bus.Done         = state == S_FIN;
  assign bus.Aborted      = aborted;
  assign bus.PID_out      = pid;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: nxt = bus.Start ? S_RD : S_IDLE;
      S_RD:   nxt = bus.Abort ? S_IDLE : S_WR;
`ifdef SWAP_CHECKSUM_EN
      S_WR:   nxt = bus.Abort ? S_IDLE : last ? S_CHK : S_RD;
      S_CHK:  nxt = bus.Abort ? S_IDLE : S_FIN;
`else
      S_WR:   nxt = bus.Abort ? S_IDLE : last ? S_FIN : S_RD;
`endif
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      k            <= '0;
      pid          <= '0;
      mp_base      <= '0;
      hd_base      <= '0;
      mp_hold      <= '0;
      hd_addr_hold <= '0;
      hd_data_hold <= '0;
      aborted      <= 1'b0;
`ifdef SWAP_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      state   <= nxt;
      aborted <= active && bus.Abort;
      if (state == S_IDLE && bus.Start) begin
        pid     <= bus.PID;
        mp_base <= bus.MP_Base;
        hd_base <= bus.HD_Base;
        k       <= '0;
`ifdef SWAP_CHECKSUM_EN
        sum     <= '0;
`endif
      end
      if (state == S_RD) mp_hold <= rd_addr;
      if (writing) begin
        hd_addr_hold <= wr_addr;
        hd_data_hold <= wr_data;
      end
      if (state == S_WR && !last) k <= k + K_W'(1);
`ifdef SWAP_CHECKSUM_EN
      if (state == S_WR) sum <= sum + bus.MP_Data;
`endif
    end
  end
endmodule
